// File: rtl/mem_arbiter.sv
// Arbitrates I-miss, D-miss and D-store requests onto one fill engine and one memory port.
// Grants take one cycle from IDLE; a fill holds the port until its last response arrives.
module mem_arbiter #(
    parameter int BEATS  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dwrite_req,
    input  logic [ADDR_W-1:0] dwrite_addr,
    input  logic [ADDR_W-1:0] dwrite_data,
    input  logic [ADDR_W-1:0] fill_mem_addr,
    input  logic              fill_write_data,
    input  logic              fill_write_tag,
    input  logic              memory_data_valid,
    output logic              miss_detected,
    output logic [ADDR_W-1:0] miss_address,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_data_in,
    output logic              icache_wr_data,
    output logic              icache_wr_tag,
    output logic              dcache_wr_data,
    output logic              dcache_wr_tag,
    output logic              ifill_done,
    output logic              dfill_done,
    output logic              dwrite_ack
);
    localparam int CW = $clog2(BEATS) + 1;

    typedef enum logic [2:0] {IDLE, START, FILL, RECOVER, WRITE} state_t;
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_owner;
    logic [CW-1:0]     r_req_cnt;
    logic [CW-1:0]     r_rsp_cnt;
    logic [ADDR_W-1:0] r_miss_addr;

    logic [ADDR_W-1:0] w_blk_mask;
    logic              w_req_active;
    logic              w_last_rsp;

    assign w_blk_mask   = ~{{(ADDR_W-4){1'b0}}, 4'hF};
    assign w_req_active = (r_state == FILL) && (r_req_cnt < CW'(BEATS));
    assign w_last_rsp   = (r_state == FILL) && memory_data_valid && (r_rsp_cnt == CW'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // D-miss outranks the store so a store to a missing block waits behind its fill.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (dcache_miss)      w_next = START;
                else if (dwrite_req)  w_next = WRITE;
                else if (icache_miss) w_next = START;
            end
            START:   w_next = FILL;
            FILL:    if (w_last_rsp) w_next = RECOVER;
            RECOVER: w_next = IDLE;
            WRITE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= OWN_NONE;
            r_req_cnt   <= '0;
            r_rsp_cnt   <= '0;
            r_miss_addr <= '0;
        end else begin
            if (r_state == IDLE && w_next == START) begin
                r_req_cnt <= '0;
                r_rsp_cnt <= '0;
                if (dcache_miss) begin
                    r_owner     <= OWN_D;
                    r_miss_addr <= dcache_addr & w_blk_mask;
                end else begin
                    r_owner     <= OWN_I;
                    r_miss_addr <= icache_addr & w_blk_mask;
                end
            end
            if (w_req_active)                         r_req_cnt <= r_req_cnt + 1'b1;
            if (r_state == FILL && memory_data_valid) r_rsp_cnt <= r_rsp_cnt + 1'b1;
            if (r_state == RECOVER)                   r_owner   <= OWN_NONE;
        end
    end

    always_comb begin
        miss_detected  = 1'b0;
        miss_address   = '0;
        mem_enable     = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = '0;
        mem_data_in    = '0;
        icache_wr_data = 1'b0;
        icache_wr_tag  = 1'b0;
        dcache_wr_data = 1'b0;
        dcache_wr_tag  = 1'b0;
        ifill_done     = 1'b0;
        dfill_done     = 1'b0;
        dwrite_ack     = 1'b0;
        case (r_state)
            START: begin
                miss_detected = 1'b1;
                miss_address  = r_miss_addr;
            end
            FILL: begin
                miss_address = r_miss_addr;
                if (w_req_active) begin
                    mem_enable = 1'b1;
                    mem_addr   = fill_mem_addr;
                end
                if (r_owner == OWN_I) begin
                    icache_wr_data = fill_write_data;
                    icache_wr_tag  = fill_write_tag;
                    ifill_done     = w_last_rsp;
                end else if (r_owner == OWN_D) begin
                    dcache_wr_data = fill_write_data;
                    dcache_wr_tag  = fill_write_tag;
                    dfill_done     = w_last_rsp;
                end
            end
            RECOVER: miss_address = r_miss_addr;
            WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = dwrite_addr;
                mem_data_in = dwrite_data;
                dwrite_ack  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Upstream front end of cache_fill_FSM. Arbitrates the I-cache miss, D-cache miss and D-cache write-through store onto one fill engine and one 4-cycle-latency, 16-bit-word memory port.
- Issues the miss_detected / miss_address pair consumed by the fill FSM.
- Routes the fill FSM's data/tag write strobes to the cache that owns the fill.
- Muxes the memory address/command between fill reads and store writes.

Parameters:
BEATS, 8, words per cache block (16-byte block of 2-byte words).
ADDR_W, 16, address/data width.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
icache_miss  in  1  I-cache miss request, level, held until served
icache_addr  in  16  I-cache miss byte address
dcache_miss  in  1  D-cache miss request, level, held until served
dcache_addr  in  16  D-cache miss byte address
dwrite_req  in  1  D-cache write-through store request, level
dwrite_addr  in  16  store byte address
dwrite_data  in  16  store data
fill_mem_addr  in  16  memory_address from fill FSM
fill_write_data  in  1  write_data_array from fill FSM
fill_write_tag  in  1  write_tag_array from fill FSM
memory_data_valid  in  1  memory read-response strobe
miss_detected  out  1  one-cycle start pulse to fill FSM
miss_address  out  16  block-aligned address to fill FSM
mem_enable  out  1  memory request valid
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  16  memory address
mem_data_in  out  16  memory write data
icache_wr_data  out  1  I-cache data-array write strobe
icache_wr_tag  out  1  I-cache tag-array write strobe
dcache_wr_data  out  1  D-cache data-array write strobe
dcache_wr_tag  out  1  D-cache tag-array write strobe
ifill_done  out  1  one-cycle pulse, I fill complete
dfill_done  out  1  one-cycle pulse, D fill complete
dwrite_ack  out  1  one-cycle pulse, store accepted by memory

Behaviour:
- Reset:
  - Asynchronous on rst_n low. State = IDLE, both counters = 0, owner = none.
  - All outputs 0 while in reset and in IDLE with no request.
  - Reset mid-fill or mid-write abandons the operation; no done/ack pulse is produced.
- States: IDLE, START, FILL, RECOVER, WRITE.
- IDLE grant priority, evaluated each cycle:
  1. dcache_miss
  2. dwrite_req
  3. icache_miss
- Because dcache_miss ranks above dwrite_req, a store to a missing block is filled first; the store is served on a later grant.
- IDLE → START on a miss grant:
  - owner is latched.
  - miss_address latched as the requesting address with bits [3:0] cleared.
- START, one cycle:
  - miss_detected = 1 and miss_address is valid.
  - Next state is FILL.
- FILL:
  - Request counter runs 0..BEATS-1, one per cycle. While it is below BEATS: mem_enable = 1, mem_wr = 0, mem_addr = fill_mem_addr.
  - Response counter increments on each memory_data_valid.
  - fill_write_data and fill_write_tag are forwarded combinationally to the owner's wr_data/wr_tag outputs only. The other cache's strobes stay 0.
  - On the cycle of the BEATS-th valid: pulse the owner's fill_done, then go to RECOVER.
  - Responses may arrive non-contiguously; the block waits indefinitely.
- RECOVER, one cycle, no grant:
  - Lets the cache re-look-up and drop its miss.
  - Next state is IDLE.
- IDLE → WRITE on a dwrite_req grant:
  - In WRITE for exactly one cycle: mem_enable = 1, mem_wr = 1, mem_addr = dwrite_addr, mem_data_in = dwrite_data, dwrite_ack = 1.
  - Next state is IDLE. Back-to-back stores therefore run at one per 2 cycles.
- Requests arriving while not in IDLE are not lost; they are served by priority when the block returns to IDLE.
- mem_data_in = 0 whenever mem_wr = 0.
- memory_data_valid outside FILL is ignored.
- Counter widths are clog2(BEATS)+1; both counters clear on entering START.

Test Plan:
1. icache_miss with icache_addr = 0x1234 → miss_detected for 1 cycle with miss_address = 0x1230; mem_enable for 8 cycles with mem_addr following fill_mem_addr; 8 valids → icache strobes only; ifill_done on the 8th valid; RECOVER; IDLE.
2. icache_miss and dcache_miss asserted in the same cycle (dcache_addr = 0x4008) → D fill with miss_address = 0x4000 completes with dfill_done; the I fill then starts exactly 2 cycles later (RECOVER, then IDLE grant → START).
3. dwrite_req with addr = 0x2002, data = 0xBEEF → next cycle mem_enable = 1, mem_wr = 1, mem_addr = 0x2002, mem_data_in = 0xBEEF, dwrite_ack = 1; back in IDLE after 1 cycle.
4. dcache_miss and dwrite_req asserted together → fill first; dwrite_ack only after dfill_done plus RECOVER.
5. icache_miss raised mid D fill, with gaps between valids (valid every 4 cycles) → no I grant until RECOVER has passed; no icache strobes during the D fill.
6. rst_n low after the 3rd valid of a fill → all outputs 0 immediately; no fill_done pulse; after release a fresh miss restarts with counters at 0.
